// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC, imem req/ack handshake, and an instruction register held stable through HOLD.
// Optional fetch timeout with error pulse when IF_FETCH_TIMEOUT_EN is defined.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          IMEM_AW   = 10,
  parameter int          TO_CYCLES = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               PC_Sel,
  input  logic               PC_LdEn,
  input  logic [31:0]        Imm,
  output logic               Imem_Req,
  output logic [IMEM_AW-1:0] Imem_Addr,
  input  logic               Imem_Ack,
  input  logic [31:0]        Imem_Data,
  output logic [31:0]        Instr,
  output logic               Instr_Valid,
  output logic [31:0]        PC,
  output logic               Busy,
  output logic               Fetch_Err
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, instr_q, pc_nxt;
  logic        vld_q;
  logic        cap, ld, to_hit;

  assign cap    = (state == FETCH) && Imem_Ack;
  assign ld     = (state == HOLD) && PC_LdEn;
  assign pc_nxt = PC_Sel ? (pc_q + 32'd4 + (Imm << 2)) : (pc_q + 32'd4);

`ifdef IF_FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
  logic [7:0] to_cnt;
  logic       err_q;

  // An ack on the expiry edge takes priority, so the hit requires !Imem_Ack.
  assign to_hit = (state == FETCH) && !Imem_Ack && (to_cnt == TO_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      to_cnt <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      err_q <= to_hit;
      if (ld)
        to_cnt <= 8'd0;
      else if ((state == FETCH) && !Imem_Ack)
        to_cnt <= to_cnt + 8'd1;
    end
  end

  assign Fetch_Err = err_q;
`else
  assign to_hit    = 1'b0;
  assign Fetch_Err = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (cap || to_hit) state_nxt = HOLD;
      HOLD:  if (ld)            state_nxt = FETCH;
      default:                  state_nxt = FETCH;
    endcase
  end

  always_comb begin
    Imem_Req = (state == FETCH);
    Busy     = (state == FETCH);
  end

  // Instr only moves on the capture/timeout edge, so it is stable for all of HOLD.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      vld_q   <= 1'b0;
    end else if (cap) begin
      instr_q <= Imem_Data;
      vld_q   <= 1'b1;
    end else if (to_hit) begin
      instr_q <= 32'h0;
      vld_q   <= 1'b1;
    end else if (ld) begin
      pc_q  <= pc_nxt;
      vld_q <= 1'b0;
    end
  end

  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign Instr_Valid = vld_q;
  assign Imem_Addr   = pc_q[IMEM_AW+1:2];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: fetch-level reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  localparam int AW = 10;
  localparam int TO = 16;

  logic          Clk = 1'b0, Reset_n = 1'b1, PC_Sel = 1'b0, PC_LdEn = 1'b0, Imem_Ack = 1'b0;
  logic [31:0]   Imm = 32'h0, Imem_Data = 32'h0;
  logic [31:0]   Instr, PC;
  logic          Imem_Req, Instr_Valid, Busy, Fetch_Err;
  logic [AW-1:0] Imem_Addr;

  int checks = 0, errors = 0;
  int mem_wait = 0;
  logic        stray_ack = 1'b0;
  logic [31:0] stray_data = 32'h0;

  always #5 Clk = ~Clk;

  if_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW), .TO_CYCLES(TO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .Imm(Imm),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data),
    .Instr(Instr), .Instr_Valid(Instr_Valid), .PC(PC), .Busy(Busy), .Fetch_Err(Fetch_Err)
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h80001234 + ({22'h0, a} << 16);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // Memory: acks mem_wait cycles into each fetch; stray acks only while not requested.
  int            wcnt = 0;
  logic          prev_req = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge Clk) begin
    if (Imem_Req) begin
      if (!prev_req || Imem_Addr != prev_addr || !Reset_n) wcnt = 0;
      else wcnt++;
      Imem_Ack  = (mem_wait >= 0) && (wcnt == mem_wait);
      Imem_Data = mem_word(Imem_Addr);
    end else begin
      Imem_Ack  = stray_ack;
      Imem_Data = stray_data;
    end
    prev_req  = Imem_Req && Reset_n;
    prev_addr = Imem_Addr;
  end

  // Reference model: one fetch in flight or one instruction held.
  logic [31:0] m_pc, m_instr;
  logic        m_vld, m_fetch, m_err;
  int          m_fcyc;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_pc <= 32'h0; m_instr <= 32'h0; m_vld <= 1'b0;
      m_fetch <= 1'b1; m_err <= 1'b0; m_fcyc <= 0;
    end else begin
      m_err <= 1'b0;
      if (m_fetch) begin
        if (Imem_Ack) begin
          m_instr <= Imem_Data; m_vld <= 1'b1; m_fetch <= 1'b0;
        end
`ifdef IF_FETCH_TIMEOUT_EN
        else if (m_fcyc + 1 == TO) begin
          m_instr <= 32'h0; m_vld <= 1'b1; m_fetch <= 1'b0; m_err <= 1'b1;
        end
`endif
        m_fcyc <= m_fcyc + 1;
      end else if (PC_LdEn) begin
        m_pc    <= m_pc + 32'd4 + (PC_Sel ? Imm * 32'd4 : 32'd0);
        m_vld   <= 1'b0;
        m_fetch <= 1'b1;
        m_fcyc  <= 0;
      end
    end
  end

  always @(negedge Clk) begin
    chk("m_pc",    PC,                  m_pc);
    chk("m_instr", Instr,               m_instr);
    chk("m_vld",   32'(Instr_Valid),    32'(m_vld));
    chk("m_req",   32'(Imem_Req),       32'(m_fetch));
    chk("m_busy",  32'(Busy),           32'(m_fetch));
    chk("m_addr",  32'(Imem_Addr),      32'(m_pc[AW+1:2]));
    chk("m_err",   32'(Fetch_Err),      32'(m_err));
  end

  task automatic tick();
    @(negedge Clk); #1;
  endtask

  task automatic load(input logic sel, input logic [31:0] imm);
    PC_Sel = sel; Imm = imm; PC_LdEn = 1'b1;
    tick();
    PC_LdEn = 1'b0; PC_Sel = 1'b0;
  endtask

  task automatic wait_hold(input int lim);
    int n = 0;
    while (Busy && n < lim) begin tick(); n++; end
    checks++;
    if (Busy) begin
      errors++;
      $display("FAIL wait_hold busy still high after %0d cycles t=%0t", lim, $time);
    end
  endtask

  initial begin
    int first_v, ecnt;
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_req", 32'(Imem_Req), 32'd1);
    chk("rst_vld", 32'(Instr_Valid), 32'd0);
    mem_wait = 0;
    tick(); tick();
    Reset_n = 1'b1;
    tick();
    chk("zw_instr", Instr, 32'h80001234);
    chk("zw_vld", 32'(Instr_Valid), 32'd1);
    chk("zw_busy", 32'(Busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
      mem_wait = i % 2;
      load(1'b0, 32'h0);
      wait_hold(20);
    end
    chk("seq_pc10", PC, 32'h10);

    mem_wait = 3;
    load(1'b0, 32'h0);
    chk("seq_pc", PC, 32'h14);
    chk("seq_addr", 32'(Imem_Addr), 32'd5);
    chk("seq_vld", 32'(Instr_Valid), 32'd0);
    PC_Sel = 1'b1; Imm = 32'd100; PC_LdEn = 1'b1;
    tick(); tick();
    PC_LdEn = 1'b0; PC_Sel = 1'b0;
    wait_hold(20);
    chk("ign_pc", PC, 32'h14);
    chk("ign_instr", Instr, mem_word(10'd5));

    mem_wait = 1;
    for (int i = 0; i < 3; i++) begin load(1'b0, 32'h0); wait_hold(20); end
    chk("pc20", PC, 32'h20);
    load(1'b1, 32'hFFFFFFFE);
    chk("br_pc", PC, 32'h1C);
    wait_hold(20);

    stray_data = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) begin stray_ack = (i % 2 == 0); tick(); end
    stray_ack = 1'b0;
    tick();
    chk("hold_instr", Instr, mem_word(10'd7));
    chk("hold_vld", 32'(Instr_Valid), 32'd1);

    mem_wait = -1;
    load(1'b1, 32'd8);
    chk("pc40", PC, 32'h40);
    tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_pc", PC, 32'h0);
    chk("arst_instr", Instr, 32'h0);
    chk("arst_vld", 32'(Instr_Valid), 32'd0);
    chk("arst_req", 32'(Imem_Req), 32'd1);
    chk("arst_addr", 32'(Imem_Addr), 32'd0);
    mem_wait = 0;
    tick();
    Reset_n = 1'b1;
    wait_hold(20);
    chk("arst_refetch", Instr, 32'h80001234);

    load(1'b1, 32'hFFFFFFFE);
    chk("wrap_top", PC, 32'hFFFFFFFC);
    mem_wait = 1;
    wait_hold(20);
    load(1'b0, 32'h0);
    chk("wrap_pc", PC, 32'h0);
    wait_hold(20);

    mem_wait = -1;
    load(1'b0, 32'h0);
    first_v = -1; ecnt = 0;
`ifdef IF_FETCH_TIMEOUT_EN
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (Fetch_Err) ecnt++;
      if (Instr_Valid && first_v < 0) first_v = k;
    end
    chk("to_cycle", 32'(first_v), 32'd16);
    chk("to_errcnt", 32'(ecnt), 32'd1);
    chk("to_instr", Instr, 32'h0);
    chk("to_busy", 32'(Busy), 32'd0);
`else
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (Fetch_Err) ecnt++;
      if (Instr_Valid && first_v < 0) first_v = k;
    end
    chk("noto_busy", 32'(Busy), 32'd1);
    chk("noto_errcnt", 32'(ecnt), 32'd0);
    chk("noto_vld", 32'(first_v), 32'hFFFFFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch unit sitting directly upstream of the control unit and the decode stage. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents a stable 32-bit `Instr` for the whole multi-cycle execution of an instruction. Applies the next-PC update (sequential or branch) when the control unit asserts `PC_LdEn`.

## Interface

Parameters:
- `RESET_PC`, default 32'h0: PC value after reset; must be word aligned.
- `IMEM_AW`, default 10: instruction memory word-address width.
- `TO_CYCLES`, default 16: fetch timeout in cycles, 2..255. Used only with `IF_FETCH_TIMEOUT_EN`.

Ports:
- `Clk`  in  1  single clock; all state changes on rising edge.
- `Reset_n`  in  1  reset, asynchronous and active-low.
- `PC_Sel`  in  1  0 = sequential next PC, 1 = branch target.
- `PC_LdEn`  in  1  load-next-PC request from control, sampled on a rising edge.
- `Imm`  in  32  sign-extended branch immediate from decode, in words.
- `Imem_Req`  out  1  read request to instruction memory.
- `Imem_Addr`  out  IMEM_AW  word address, equal to `PC[IMEM_AW+1:2]`.
- `Imem_Ack`  in  1  read data valid.
- `Imem_Data`  in  32  read data.
- `Instr`  out  32  current instruction register.
- `Instr_Valid`  out  1  `Instr` holds the word at `PC`.
- `PC`  out  32  current program counter.
- `Busy`  out  1  fetch in progress; `PC_LdEn` is ignored while high.
- `Fetch_Err`  out  1  one-cycle timeout pulse; tied 0 without the macro.

## Operation

- Two-state FSM, FETCH and HOLD.
- `Imem_Req` and `Busy` equal (state==FETCH). Outputs are derived only from registers.
- FETCH:
  - `Imem_Addr` is held stable from `PC`.
  - On a sampled `Imem_Ack`: `Instr` <= `Imem_Data`, `Instr_Valid` <= 1, state -> HOLD.
  - `PC_LdEn` is ignored.
- HOLD:
  - `Instr` and `PC` are frozen. `Imem_Ack` is ignored.
  - On a sampled `PC_LdEn`:
    - `PC` <= `PC_Sel` ? `PC`+4+(`Imm`<<2) : `PC`+4.
    - `Instr_Valid` <= 0. `Instr` is retained.
    - state -> FETCH.
- Arithmetic: 32-bit and modulo 2^32; wrap-around past 32'hFFFFFFFC is legal. `Imm`<<2 discards `Imm[31:30]`. PC alignment is preserved by construction.
- `PC_Sel` is sampled only on the same edge as `PC_LdEn` in HOLD.
- Reset, asserted at any time including mid-fetch: `PC`=`RESET_PC`, `Instr`=32'h0 (nop encoding), `Instr_Valid`=0, `Fetch_Err`=0, timeout counter=0, state=FETCH. `Imem_Req` is therefore 1 immediately after reset.
- A pending memory response aborted by reset is not tracked. Memory must drop an outstanding `Imem_Ack` when it sees `Imem_Req` low or a new address.

## Timing

- From the `PC_LdEn` edge, `Imem_Req` rises in the same clock cycle, driven by the state register.
- Zero-wait memory (`Imem_Ack` high in the first FETCH cycle): `Instr` and `Instr_Valid` update at the next edge. Minimum fetch is 1 cycle.
- W-wait memory: `Instr` updates W+1 edges after entering FETCH.
- Minimum back-to-back instruction period is the control sequence length plus 1 fetch cycle. The control unit must not assert `PC_LdEn` again before `Instr_Valid` returns high.
- `Instr` changes only on the edge that captures `Imem_Data`. This guarantees it is stable throughout HOLD.

## Configuration

- Macro: `IF_FETCH_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entering FETCH and increments each FETCH cycle without `Imem_Ack`.
  - When the count reaches `TO_CYCLES`-1 without ack: `Instr` <= 32'h0, `Instr_Valid` <= 1, `Fetch_Err` pulses high for one cycle, state -> HOLD.
  - An ack arriving on that same edge wins: data is captured and there is no error.
- Not defined: FETCH waits indefinitely, no counter logic is present, and `Fetch_Err` is constant 0.

## Test plan

- Reset: `Reset_n` low mid-fetch at `PC`=0x40 -> `PC`=`RESET_PC`=0, `Instr`=0, `Instr_Valid`=0, `Imem_Req`=1, `Imem_Addr`=0, asynchronously (before the next `Clk` edge).
- Zero-wait fetch: memory returns 0x80001234 for addr 0 with `Imem_Ack` high in the first FETCH cycle -> next edge `Instr`=0x80001234, `Instr_Valid`=1, `Busy`=0.
- Sequential load: HOLD at `PC`=0x10, `PC_LdEn`=1, `PC_Sel`=0 -> `PC`=0x14, `Imem_Addr`=5, `Instr_Valid`=0. `PC_LdEn` pulses during the following 3-wait fetch are ignored.
- Branch: `PC`=0x20, `Imm`=0xFFFFFFFE, `PC_Sel`=1 -> `PC`=0x1C. Wrap: `PC`=0xFFFFFFFC, sequential -> `PC`=0x0.
- Ack in HOLD: `Imem_Ack` toggled with new data during HOLD -> `Instr` unchanged.
- Timeout, with the macro and `TO_CYCLES`=16: no ack -> after 16 FETCH cycles `Instr`=0, `Instr_Valid`=1, `Fetch_Err` high exactly 1 cycle. Without the macro: still FETCH after 100 cycles.
